// File: rtl/rah_pkg.sv
// Shared constants for the result FIFO: word width, words per bundle and slice order.
// Used by both the divider-side writer and the reader-side collector.
package rah_pkg;

    localparam int RAH_DATA_W = 48;
    localparam int RAH_WORDS  = 3;
    localparam int RAH_BUN_W  = RAH_DATA_W * RAH_WORDS;
    localparam int RAH_CNT_W  = 16;

    // Word idx of a bundle (0 = first read) occupies bits [lsb +: data_w]; word 0 is the top slice.
    function automatic int slot_lsb(input int idx, input int words, input int data_w);
        return (words - 1 - idx) * data_w;
    endfunction

endpackage

// File: rtl/rah_result_collector.sv
// Reader end of the result FIFO: gathers WORDS consecutive words into one bundle
// and presents it on a valid/ready output register.
module rah_result_collector
    import rah_pkg::*;
#(
    parameter int DATA_W = RAH_DATA_W,
    parameter int WORDS  = RAH_WORDS,
    parameter int BUN_W  = DATA_W * WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              empty,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUN_W-1:0]  out_data,
    output logic [15:0]       bundle_cnt
);

    localparam int IDX_W = $clog2(WORDS + 1);
    localparam logic [IDX_W-1:0] FULL = IDX_W'(WORDS);

    logic [IDX_W-1:0] req_cnt;
    logic [IDX_W-1:0] cap_cnt;
    logic             rd_vld;
    logic [BUN_W-1:0] staging;
    logic             xfer;

    // rst_n is folded in so no read strobe escapes while the counters are held in reset.
    assign rd_en = rst_n & ~empty & ~flush & (req_cnt < FULL);
    assign xfer  = (cap_cnt == FULL) & (~out_valid | out_ready);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_cnt <= '0;
            cap_cnt <= '0;
            rd_vld  <= 1'b0;
            staging <= '0;
        end else begin
            rd_vld <= rd_en;
            if (flush) begin
                req_cnt <= '0;
                cap_cnt <= '0;
                staging <= '0;
            end else if (xfer) begin
                req_cnt <= '0;
                cap_cnt <= '0;
            end else begin
                if (rd_en) begin
                    req_cnt <= req_cnt + IDX_W'(1);
                end
                if (rd_vld) begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (cap_cnt == IDX_W'(i)) begin
                            staging[slot_lsb(i, WORDS, DATA_W) +: DATA_W] <= rd_data;
                        end
                    end
                    cap_cnt <= cap_cnt + IDX_W'(1);
                end
            end
        end
    end

    // Output register is independent of flush: a presented bundle is never withdrawn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            bundle_cnt <= '0;
        end else begin
            if (xfer) begin
                out_data  <= staging;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) begin
                bundle_cnt <= bundle_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rah_result_collector.sv
// Self-checking bench for rah_result_collector: a queue-backed FIFO model feeds words,
// expected bundles are plain concatenations of the words in read order.
module tb_rah_result_collector;

    localparam int DW = 48;
    localparam int BW = 144;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          empty;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic [15:0]   bundle_cnt;

    logic [DW-1:0] q[$];
    int            pushed = 0;
    int            popped = 0;
    int            rd_count = 0;
    bit            hold_empty = 1'b0;
    logic [15:0]   exp_cnt = 16'd0;
    int            checks = 0;
    int            errors = 0;

    assign empty = hold_empty | (pushed == popped);

    always #5 clk = ~clk;

    rah_result_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .empty      (empty),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .bundle_cnt (bundle_cnt)
    );

    // FIFO model: a strobe seen in a cycle returns the head word 1 ns after the next edge.
    initial begin
        bit take;
        rd_data = '0;
        forever begin
            @(negedge clk);
            take = rd_en;
            if (take) rd_count++;
            @(posedge clk);
            #1;
            if (take && q.size() > 0) begin
                rd_data = q.pop_front();
                popped++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [DW-1:0] w);
        q.push_back(w);
        pushed++;
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    function automatic logic [BW-1:0] pack(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                           input logic [DW-1:0] w2);
        return {w0, w1, w2};
    endfunction

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        ok = (out_valid === 1'b1);
    endtask

    task automatic wait_drained(output bit ok);
        int n = 0;
        while (popped != pushed && n < 100) begin
            tick();
            n++;
        end
        ok = (popped == pushed);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        if (out_valid === 1'b1) exp_cnt++;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push(48'hAAAA_0000_0001);
        push(48'hBBBB_0000_0002);
        push(48'hCCCC_0000_0003);
        repeat (2) tick();
        checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++;
        if (bundle_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h want 0", bundle_cnt); end
    endtask

    task automatic test_basic();
        int highs = 0, run = 0, maxrun = 0;
        bit ok;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rd_en === 1'b1) begin
                highs++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        checks++;
        if (highs != 3 || maxrun != 3) begin
            errors++;
            $display("FAIL basic_rd_en: got %0d reads (run %0d) want 3 consecutive", highs, maxrun);
        end
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== pack(48'hAAAA_0000_0001, 48'hBBBB_0000_0002, 48'hCCCC_0000_0003)) begin
            errors++;
            $display("FAIL basic_bundle: got %h valid %b", out_data, out_valid);
        end
        handshake();
        checks++;
        if (bundle_cnt !== exp_cnt || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_cnt: got %h valid %b want %h valid 0", bundle_cnt, out_valid, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w[6];
        logic [BW-1:0] b1, b2;
        int base;
        bit ok;
        out_ready = 1'b0;
        base = rd_count;
        foreach (w[i]) begin
            w[i] = rand_word();
            push(w[i]);
        end
        b1 = pack(w[0], w[1], w[2]);
        b2 = pack(w[3], w[4], w[5]);
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== b1) begin errors++; $display("FAIL bp_first: got %h want %h", out_data, b1); end
        repeat (20) tick();
        checks++;
        if (rd_count - base != 6 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_reads: got %0d reads rd_en %b want 6 reads rd_en 0", rd_count - base, rd_en);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== b1) begin
            errors++;
            $display("FAIL bp_hold: got %h valid %b want %h", out_data, out_valid, b1);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b1 || out_data !== b2 || bundle_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL bp_second: got %h cnt %h want %h cnt %h", out_data, bundle_cnt, b2, exp_cnt);
        end
        handshake();
    endtask

    task automatic test_empty_pause();
        logic [DW-1:0] w0, w1, w2;
        bit ok;
        w0 = rand_word(); w1 = rand_word(); w2 = rand_word();
        push(w0);
        wait_drained(ok);
        hold_empty = 1'b1;
        push(w1);
        push(w2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rd_en !== 1'b0) begin errors++; $display("FAIL pause_rd_en: cycle %0d got %b want 0", i, rd_en); end
        end
        @(posedge clk);
        #2;
        hold_empty = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== pack(w0, w1, w2)) begin
            errors++;
            $display("FAIL pause_bundle: got %h want %h", out_data, pack(w0, w1, w2));
        end
        handshake();
    endtask

    task automatic test_flush();
        logic [DW-1:0] w[5];
        bit ok;
        foreach (w[i]) w[i] = rand_word();
        push(w[0]);
        push(w[1]);
        wait_drained(ok);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) tick();
        checks++;
        if (!ok || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got valid %b want 0", out_valid);
        end
        push(w[2]);
        push(w[3]);
        push(w[4]);
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== pack(w[2], w[3], w[4])) begin
            errors++;
            $display("FAIL flush_bundle: got %h want %h", out_data, pack(w[2], w[3], w[4]));
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w[3];
        bit ok;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(rand_word());
        wait_valid(ok);
        wait_drained(ok);
        repeat (2) tick();
        rst_n = 1'b0;
        exp_cnt = 16'd0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || bundle_cnt !== 16'd0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid %b data %h cnt %h rd_en %b want all 0",
                     out_valid, out_data, bundle_cnt, rd_en);
        end
        tick();
        rst_n = 1'b1;
        foreach (w[i]) begin
            w[i] = rand_word();
            push(w[i]);
        end
        wait_valid(ok);
        checks++;
        if (!ok || out_data !== pack(w[0], w[1], w[2])) begin
            errors++;
            $display("FAIL midreset_bundle: got %h want %h", out_data, pack(w[0], w[1], w[2]));
        end
        handshake();
        checks++;
        if (bundle_cnt !== exp_cnt) begin errors++; $display("FAIL midreset_cnt: got %h want %h", bundle_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        logic [DW-1:0] w[3];
        logic [BW-1:0] exp;
        bit ok;
        for (int n = 0; n < 10; n++) begin
            exp = '0;
            foreach (w[i]) begin
                w[i] = rand_word();
                exp = (exp << DW) | BW'(w[i]);
                push(w[i]);
                hold_empty = ($urandom_range(0, 3) == 0);
                repeat ($urandom_range(0, 2)) tick();
                hold_empty = 1'b0;
            end
            wait_valid(ok);
            repeat ($urandom_range(0, 3)) tick();
            checks++;
            if (!ok || out_valid !== 1'b1 || out_data !== exp) begin
                errors++;
                $display("FAIL random_bundle[%0d]: got %h want %h", n, out_data, exp);
            end
            handshake();
        end
        checks++;
        if (bundle_cnt !== exp_cnt) begin errors++; $display("FAIL random_cnt: got %h want %h", bundle_cnt, exp_cnt); end
    endtask

    task automatic test_wrap();
        bit ok;
        force dut.bundle_cnt = 16'hFFFE;
        tick();
        release dut.bundle_cnt;
        exp_cnt = 16'hFFFE;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 3; i++) push(rand_word());
            wait_valid(ok);
            handshake();
            checks++;
            if (!ok || bundle_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL wrap_cnt[%0d]: got %h want %h", n, bundle_cnt, exp_cnt);
            end
        end
        checks++;
        if (bundle_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", bundle_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_pause();
        test_flush();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rah_result_collector.md
RAH_RESULT_COLLECTOR -- requirements
Module: rah_result_collector

Interface
REQ-001 Parameter DATA_W, default 48, FIFO word width in bits.
REQ-002 Parameter WORDS, default 3, FIFO words per bundle; bundle width BUN_W = DATA_W*WORDS (default 144).
REQ-003 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port empty  input  1  result FIFO empty flag.
REQ-006 Port rd_en  output  1  FIFO read strobe; read data arrives exactly one cycle later.
REQ-007 Port rd_data  input  DATA_W  FIFO read data, valid in the cycle after rd_en.
REQ-008 Port flush  input  1  synchronous discard of any partially collected bundle.
REQ-009 Port out_valid  output  1  out_data holds a complete bundle.
REQ-010 Port out_ready  input  1  consumer accepts the bundle when high with out_valid.
REQ-011 Port out_data  output  BUN_W  assembled bundle.
REQ-012 Port bundle_cnt  output  16  count of bundles accepted by the consumer.

Function
REQ-013 The block SHALL be the reader end of the result FIFO: it reassembles WORDS consecutive DATA_W words into one BUN_W bundle.
REQ-014 The first word read of a bundle SHALL land in out_data[BUN_W-1 -: DATA_W], and each later word in the next lower DATA_W slice; the last word lands in [DATA_W-1:0].
REQ-015 Counter req_cnt (0..WORDS) counts reads issued for the current bundle; rd_en SHALL be combinational: ~empty & ~flush & (req_cnt < WORDS).
REQ-016 A registered rd_vld SHALL equal the previous cycle's rd_en; when rd_vld is high and flush is low, rd_data SHALL be written into the staging-register slot indexed by cap_cnt, and cap_cnt SHALL increment.
REQ-017 Back-to-back reads SHALL be supported; three words with empty held low SHALL take three consecutive rd_en cycles.
REQ-018 When cap_cnt == WORDS and (out_valid == 0 or out_ready == 1), the staging register SHALL transfer to out_data, out_valid SHALL be 1 next cycle, and req_cnt and cap_cnt SHALL clear to 0.
REQ-019 While a full staging bundle waits for transfer, rd_en SHALL stay low because req_cnt == WORDS, so no FIFO word is lost.
REQ-020 out_valid SHALL clear on out_valid & out_ready unless a transfer occurs in the same cycle; out_data SHALL stay stable while out_valid & ~out_ready.
REQ-021 bundle_cnt SHALL increment by 1 on each out_valid & out_ready and wrap from 0xFFFF to 0.
REQ-022 On flush, req_cnt, cap_cnt and the staging register SHALL clear, and any rd_vld word in that cycle SHALL be discarded; out_valid, out_data and bundle_cnt SHALL not be affected.
REQ-023 If empty rises mid-bundle, collection SHALL pause and resume with the correct slot when empty falls.

Reset
REQ-024 On rst_n low, these SHALL reset asynchronously: out_valid=0, out_data=0, bundle_cnt=0, req_cnt=0, cap_cnt=0, rd_vld=0, staging=0. rd_en SHALL be 0 during reset.
REQ-025 Reset asserted mid-bundle SHALL drop the partial bundle; the first read after release starts a new bundle at the top slice.

Structure
REQ-026 DATA_W, WORDS and the bundle slice-order constants SHALL live in a shared package (rah_pkg), shared with the divider-side writer.
REQ-027 The block SHALL be a single module with no sub-modules; counters, staging register and output register are inline.

Verification
REQ-028 Reset release, then FIFO words 0xAAAA_0000_0001, 0xBBBB_0000_0002, 0xCCCC_0000_0003 with empty low -> rd_en high for 3 consecutive cycles; then out_valid with out_data = {A..1, B..2, C..3}.
REQ-029 out_ready held low with 6 words available -> first bundle held stable; exactly 3 further reads, then rd_en low; raising out_ready -> second bundle on out_data next cycle and bundle_cnt = 1.
REQ-030 empty pulses high for 2 cycles after the first word -> no read while empty; the bundle still assembles in order.
REQ-031 flush in the cycle after the second word's rd_en -> that word discarded; the next 3 words form a clean bundle.
REQ-032 rst_n low after 2 words captured -> all outputs 0 immediately; after release, 3 new words produce a correct bundle.
REQ-033 Preload bundle_cnt = 0xFFFF by driving 65535 handshakes, then one more -> bundle_cnt = 0x0000.
